// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin arbiter/sequencer sharing one gcd FSMD between
// N four-phase clients.
// The granted client's operands are serialised onto the gcd unit's single
// AB bus: A is loaded first, then B. The result comes back on gcd_c.
// Zero operands never reach the gcd unit, because it would not terminate
// on them; they are resolved locally.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   cl_req/cl_a/cl_b    per-client request and operands (slice i*W +: W)
//   cl_ack/cl_c         per-client acknowledge and the shared result bus
//   busy, grant         state != IDLE; index of the current/last served client
//   gcd_req/gcd_ab      request and operand bus to the gcd unit
//   gcd_ack/gcd_c       acknowledge and result from the gcd unit
module gcd_arbiter #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         cl_req,
  input  logic [N*W-1:0]       cl_a,
  input  logic [N*W-1:0]       cl_b,
  output logic [N-1:0]         cl_ack,
  output logic [W-1:0]         cl_c,
  output logic                 busy,
  output logic [$clog2(N)-1:0] grant,
  output logic                 gcd_req,
  output logic [W-1:0]         gcd_ab,
  input  logic                 gcd_ack,
  input  logic [W-1:0]         gcd_c
);

  localparam int GW = $clog2(N);

  typedef enum logic [2:0] {
    IDLE, GRANT, LOAD_A, DROP_A, LOAD_B, CAPTURE, RELEASE, RESP
  } state_e;

  state_e              state_q, state_d;
  logic [GW-1:0]       ptr_q, ptr_d, grant_q, grant_d, sel;
  logic [W-1:0]        op_a_q, op_a_d, op_b_q, op_b_d, res_q, res_d;
  logic [W-1:0]        gcd_ab_q, gcd_ab_d;
  logic                gcd_req_q, gcd_req_d, found;
  logic [N-1:0]        cl_ack_q, cl_ack_d;
  logic [N-1:0][W-1:0] a_arr, b_arr;

  for (genvar i = 0; i < N; i++) begin : g_slice
    assign a_arr[i] = cl_a[i*W +: W];
    assign b_arr[i] = cl_b[i*W +: W];
  end

  // First requester at or above ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && cl_req[(int'(ptr_q) + k) % N]) begin
        found = 1'b1;
        sel   = GW'((int'(ptr_q) + k) % N);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    res_d    = res_q;
    gcd_ab_d = gcd_ab_q;
    cl_ack_d = '0;
    case (state_q)
      IDLE: if (found) begin
        state_d = GRANT;
        grant_d = sel;
        op_a_d  = a_arr[sel];
        op_b_d  = b_arr[sel];
      end
      GRANT: begin
        if (op_a_q == '0 || op_b_q == '0) begin
          // If A is zero the result is B, which also covers both being zero.
          res_d   = (op_a_q == '0) ? op_b_q : op_a_q;
          state_d = RESP;
        end else begin
          state_d = LOAD_A;
        end
      end
      LOAD_A:  if (gcd_ack)  state_d = DROP_A;
      DROP_A:  if (!gcd_ack) state_d = LOAD_B;
      LOAD_B:  if (gcd_ack)  state_d = CAPTURE;
      CAPTURE: begin
        res_d   = gcd_c;
        state_d = RELEASE;
      end
      RELEASE: if (!gcd_ack) state_d = RESP;
      RESP: if (!cl_req[grant_q]) begin
        ptr_d   = (grant_q == GW'(N - 1)) ? '0 : grant_q + GW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // gcd-side outputs are registered from the next state.
    // gcd_ab keeps its last value outside the load states.
    gcd_req_d = (state_d == LOAD_A) || (state_d == LOAD_B) || (state_d == CAPTURE);
    if (state_d == LOAD_A || state_d == DROP_A) gcd_ab_d = op_a_q;
    else if (state_d == LOAD_B)                 gcd_ab_d = op_b_q;

    // Ack is raised only while the client still requests. A client that
    // dropped early therefore sees no ack pulse on its way through RESP.
    if (state_d == RESP && cl_req[grant_d]) cl_ack_d[grant_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      res_q     <= '0;
      gcd_ab_q  <= '0;
      gcd_req_q <= 1'b0;
      cl_ack_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      res_q     <= res_d;
      gcd_ab_q  <= gcd_ab_d;
      gcd_req_q <= gcd_req_d;
      cl_ack_q  <= cl_ack_d;
    end
  end

  assign cl_ack  = cl_ack_q;
  assign cl_c    = res_q;
  assign busy    = (state_q != IDLE);
  assign grant   = grant_q;
  assign gcd_req = gcd_req_q;
  assign gcd_ab  = gcd_ab_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter, with a behavioural two-load gcd unit
// modelled by subtraction.
module tb_gcd_arbiter;
  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   cl_req = '0;
  logic [N*W-1:0] cl_a = '0, cl_b = '0;
  logic [N-1:0]   cl_ack;
  logic [W-1:0]   cl_c, gcd_ab, gcd_c;
  logic           busy, gcd_req, gcd_ack;
  logic [1:0]     grant;

  gcd_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .reset(reset), .cl_req(cl_req), .cl_a(cl_a), .cl_b(cl_b),
    .cl_ack(cl_ack), .cl_c(cl_c), .busy(busy), .grant(grant),
    .gcd_req(gcd_req), .gcd_ab(gcd_ab), .gcd_ack(gcd_ack), .gcd_c(gcd_c)
  );

  always #5 clk = ~clk;

  // gcd unit model: latch A, drop ack, latch B, subtract until equal, ack with C.
  localparam logic [2:0] M_IDLE = 3'd0, M_GOT_A = 3'd1, M_WAIT_B = 3'd2,
                         M_COMP = 3'd3, M_DONE = 3'd4;
  logic [2:0]   m_st;
  logic [W-1:0] m_a, m_x, m_y, m_c;
  logic         m_ack;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_st <= M_IDLE; m_ack <= 1'b0; m_a <= '0; m_x <= '0; m_y <= '0; m_c <= '0;
    end else begin
      case (m_st)
        M_IDLE:   if (gcd_req) begin m_a <= gcd_ab; m_ack <= 1'b1; m_st <= M_GOT_A; end
        M_GOT_A:  if (!gcd_req) begin m_ack <= 1'b0; m_st <= M_WAIT_B; end
        M_WAIT_B: if (gcd_req) begin m_x <= m_a; m_y <= gcd_ab; m_st <= M_COMP; end
        M_COMP: begin
          if (m_x == m_y) begin m_c <= m_x; m_ack <= 1'b1; m_st <= M_DONE; end
          else if (m_x > m_y) m_x <= m_x - m_y;
          else m_y <= m_y - m_x;
        end
        M_DONE:   if (!gcd_req) begin m_ack <= 1'b0; m_st <= M_IDLE; end
        default:  m_st <= M_IDLE;
      endcase
    end
  end

  assign gcd_ack = m_ack;
  // A junk value stands in for high-Z outside the result phase.
  assign gcd_c   = (m_st == M_DONE) ? m_c : 16'hDEAD;

  // Monitors: gcd_req rising edges, and more than one cl_ack bit high at once.
  int   rises = 0;
  logic req_prev = 1'b0;
  logic multi_ack = 1'b0;
  always @(negedge clk) begin
    if (gcd_req && !req_prev) rises <= rises + 1;
    req_prev <= gcd_req;
    if ($countones(cl_ack) > 1) multi_ack <= 1'b1;
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    cl_a[i*W +: W] = 16'(a);
    cl_b[i*W +: W] = 16'(b);
  endtask

  task automatic wait_any_ack(output int cyc);
    cyc = 0;
    do begin tick(); cyc++; end while (cl_ack == '0 && cyc < 400);
  endtask

  // One complete four-phase transaction on a single client.
  task automatic do_req(input string tag, input int i, input int a, input int b,
                        input int exp, output int cyc);
    set_op(i, a, b);
    cl_req[i] = 1'b1;
    wait_any_ack(cyc);
    chk({tag, "_ack"}, 32'(cl_ack), 32'(1 << i));
    chk({tag, "_c"}, 32'(cl_c), 32'(exp));
    chk({tag, "_grant"}, 32'(grant), 32'(i));
    cl_req[i] = 1'b0;
    tick();
    chk({tag, "_ackdrop"}, 32'(cl_ack), 0);
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask

  int cyc, r0;
  int ord[5]    = '{0, 1, 2, 3, 0};
  int rr_res[4] = '{4, 5, 7, 3};
  logic seen_ack;

  initial begin
    #3 reset = 1'b0;
    #1;
    chk("rst_ack", 32'(cl_ack), 0);
    chk("rst_c", 32'(cl_c), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_gcdreq", 32'(gcd_req), 0);
    chk("rst_gcdab", 32'(gcd_ab), 0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Single client.
    r0 = rises;
    do_req("single", 0, 12, 18, 6, cyc);
    chk("single_rises", 32'(rises - r0), 2);

    // Equal operands.
    do_req("equal", 0, 7, 7, 7, cyc);

    // Zero bypass on clients 1..3, which leaves ptr at 0.
    r0 = rises;
    do_req("byp09", 1, 0, 9, 9, cyc);
    chk("byp09_lat", 32'(cyc), 2);
    do_req("byp50", 2, 5, 0, 5, cyc);
    chk("byp50_lat", 32'(cyc), 2);
    do_req("byp00", 3, 0, 0, 0, cyc);
    chk("byp00_lat", 32'(cyc), 2);
    chk("byp_norises", 32'(rises - r0), 0);

    // Round-robin: all four request; client 0 re-requests after its turn.
    set_op(0, 12, 8); set_op(1, 15, 25); set_op(2, 21, 14); set_op(3, 9, 6);
    cl_req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_any_ack(cyc);
      chk("rr_ack", 32'(cl_ack), 32'(1 << ord[j]));
      chk("rr_c", 32'(cl_c), 32'(rr_res[ord[j]]));
      chk("rr_grant", 32'(grant), 32'(ord[j]));
      cl_req[ord[j]] = 1'b0;
      tick();
      chk("rr_ackdrop", 32'(cl_ack), 0);
      if (j == 0) cl_req[0] = 1'b1;
    end

    // Early request drop on client 1 (ptr 1 -> 2): gcd completes, no ack pulse.
    set_op(1, 12, 18);
    cl_req[1] = 1'b1;
    cyc = 0;
    do begin tick(); cyc++; end while (!gcd_req && cyc < 50);
    cl_req[1] = 1'b0;
    seen_ack = 1'b0;
    cyc = 0;
    do begin tick(); cyc++; if (cl_ack != '0) seen_ack = 1'b1; end
      while (busy && cyc < 400);
    chk("abuse_noack", 32'(seen_ack), 0);
    chk("abuse_idle", 32'(busy), 0);

    // Client 2 bypass moves ptr to 3; then clients 1 and 3 request together.
    do_req("ptr3", 2, 0, 4, 4, cyc);
    set_op(1, 35, 14); set_op(3, 8, 12);
    cl_req = 4'b1010;
    wait_any_ack(cyc);
    chk("wrap_first", 32'(cl_ack), 32'b1000);
    chk("wrap_first_c", 32'(cl_c), 4);
    cl_req[3] = 1'b0;
    tick();
    wait_any_ack(cyc);
    chk("wrap_second", 32'(cl_ack), 32'b0010);
    chk("wrap_second_c", 32'(cl_c), 7);
    cl_req[1] = 1'b0;
    tick();

    // Reset during LOAD_B of (1071,462).
    set_op(2, 1071, 462);
    cl_req[2] = 1'b1;
    cyc = 0;
    do begin tick(); cyc++; end while (!(gcd_req && gcd_ab == 16'd462) && cyc < 100);
    chk("mid_loadb", 32'(gcd_ab), 462);
    tick();
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_ack", 32'(cl_ack), 0);
    chk("mid_rst_c", 32'(cl_c), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_grant", 32'(grant), 0);
    chk("mid_rst_gcdreq", 32'(gcd_req), 0);
    chk("mid_rst_gcdab", 32'(gcd_ab), 0);
    cl_req = '0;
    tick(); tick();
    reset = 1'b1;
    tick();
    do_req("fresh", 2, 1071, 462, 21, cyc);

    chk("onehot_ack", 32'(multi_ack), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
